seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 57 +++++
 rtl/bin2bcd_seq.sv | 59 +++++
 rtl/seg_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the two-digit sum display.
package seg_pkg;

    localparam int unsigned SUM_W   = 5;
    localparam int unsigned BCD_W   = 4;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned CON_W   = 2;

    // Segment patterns abcdefg+dp, bit7 = a, active-high, dp held low
    localparam logic [SEG_W-1:0] SEG_0     = 8'b11111100;
    localparam logic [SEG_W-1:0] SEG_1     = 8'b01100000;
    localparam logic [SEG_W-1:0] SEG_2     = 8'b11011010;
    localparam logic [SEG_W-1:0] SEG_3     = 8'b11110010;
    localparam logic [SEG_W-1:0] SEG_4     = 8'b01100110;
    localparam logic [SEG_W-1:0] SEG_5     = 8'b10110110;
    localparam logic [SEG_W-1:0] SEG_6     = 8'b10111110;
    localparam logic [SEG_W-1:0] SEG_7     = 8'b11100000;
    localparam logic [SEG_W-1:0] SEG_8     = 8'b11111110;
    localparam logic [SEG_W-1:0] SEG_9     = 8'b11110110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'b00000000;

    localparam logic [CON_W-1:0] DIGIT_CON_UNITS = 2'b10;
    localparam logic [CON_W-1:0] DIGIT_CON_TENS  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Committed display value
    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] units;
    } bcd_pair_t;

    // BCD digit to segment pattern; non-decimal codes blank the digit
    function automatic logic [SEG_W-1:0] seg_decode(input logic [BCD_W-1:0] d);
        logic [SEG_W-1:0] seg;
        seg = SEG_BLANK;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 5-bit binary to two BCD digits, one shift per clock.
// done flags the cycle in which the final shift is performed, so the caller
// can advance on the same edge that makes bcd_tens/bcd_units valid.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] bin_in,
    output logic             done,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_units
);

    localparam int unsigned BIT_CNT_W = $clog2(SUM_W + 1);
    localparam int unsigned SHIFT_W   = 2 * BCD_W + SUM_W;

    logic [SUM_W-1:0]     bin_q;
    logic [2*BCD_W-1:0]   bcd_q;
    logic [BIT_CNT_W-1:0] cnt_q;
    logic [2*BCD_W-1:0]   adj_c;

    // Add-3 correction of each BCD nibble ahead of the shift
    always_comb begin
        adj_c = bcd_q;
        if (adj_c[BCD_W-1:0] >= BCD_W'(5)) begin
            adj_c[BCD_W-1:0] = adj_c[BCD_W-1:0] + BCD_W'(3);
        end
        if (adj_c[2*BCD_W-1:BCD_W] >= BCD_W'(5)) begin
            adj_c[2*BCD_W-1:BCD_W] = adj_c[2*BCD_W-1:BCD_W] + BCD_W'(3);
        end
    end

    // Load on start, then shift once per clock until the bit count runs out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (start) begin
            bin_q <= bin_in;
            bcd_q <= '0;
            cnt_q <= BIT_CNT_W'(SUM_W);
            done  <= 1'b0;
        end else if (cnt_q != '0) begin
            {bcd_q, bin_q} <= SHIFT_W'({adj_c, bin_q} << 1);
            cnt_q          <= cnt_q - BIT_CNT_W'(1);
            done           <= (cnt_q == BIT_CNT_W'(2));
        end else begin
            done <= 1'b0;
        end
    end

    assign bcd_tens  = bcd_q[2*BCD_W-1:BCD_W];
    assign bcd_units = bcd_q[BCD_W-1:0];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Two-digit multiplexed 7-segment driver for a 5-bit adder result.
// Accepts a sum, converts it to BCD, commits both digits at once and scans
// units/tens slots of REFRESH_DIV clocks each.
// Optional: define SEG_LEADING_BLANK_EN to blank a leading zero in the tens slot.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_valid,
    output logic             sum_ready,
    output logic             busy,
    output logic [SEG_W-1:0] digit_seg,
    output logic [CON_W-1:0] digit_con
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t           state_q;
    state_t           state_d;
    logic             start_c;
    logic             commit_c;
    logic             ready_q;
    logic             conv_done;
    logic [BCD_W-1:0] conv_tens;
    logic [BCD_W-1:0] conv_units;
    bcd_pair_t        disp_q;
    logic [CNT_W-1:0] refresh_q;
    logic             slot_end_c;
    logic [SEG_W-1:0] next_seg_c;

    bin2bcd_seq u_bin2bcd (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_c),
        .bin_in    (sum_in),
        .done      (conv_done),
        .bcd_tens  (conv_tens),
        .bcd_units (conv_units)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and control strobes
    always_comb begin
        state_d  = state_q;
        start_c  = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sum_valid) begin
                    start_c = 1'b1;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit_c = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake flags track the state the FSM is entering
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
            busy    <= 1'b0;
        end else begin
            ready_q <= (state_d == ST_IDLE);
            busy    <= (state_d != ST_IDLE);
        end
    end

    // Ready is held low while reset is asserted and is usable on the first edge after release
    assign sum_ready = ready_q & rst_n;

    // Both display digits update together from the finished conversion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
        end else if (commit_c) begin
            disp_q <= '{tens: conv_tens, units: conv_units};
        end
    end

    assign slot_end_c = (refresh_q == CNT_W'(REFRESH_DIV - 1));

    // Pattern for the slot that starts at the next boundary
    always_comb begin
        next_seg_c = seg_decode(disp_q.units);
        if (digit_con == DIGIT_CON_UNITS) begin
            next_seg_c = seg_decode(disp_q.tens);
`ifdef SEG_LEADING_BLANK_EN
            if (disp_q.tens == '0) begin
                next_seg_c = SEG_BLANK;
            end
`endif
        end
    end

    // Slot timer; digit select and pattern change together at the boundary only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            digit_con <= DIGIT_CON_UNITS;
            digit_seg <= SEG_0;
        end else if (slot_end_c) begin
            refresh_q <= '0;
            digit_con <= (digit_con == DIGIT_CON_UNITS) ? DIGIT_CON_TENS : DIGIT_CON_UNITS;
            digit_seg <= next_seg_c;
        end else begin
            refresh_q <= refresh_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: scoreboard of per-slot display expectations plus
// handshake timing, reset abort and mid-slot commit checks.
module tb_seg_scan_ctrl;

    localparam int unsigned DIV  = 8;
    localparam int unsigned DIV2 = 2;

`ifdef SEG_LEADING_BLANK_EN
    localparam logic [7:0] TENS_ZERO = 8'b00000000;
`else
    localparam logic [7:0] TENS_ZERO = 8'b11111100;
`endif

    typedef struct packed {
        logic [7:0] tens;
        logic [7:0] units;
    } exp_t;

    typedef struct packed {
        logic [4:0] value;
        logic       interfere;
        logic [7:0] tens;
        logic [7:0] units;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] sum_in;
    logic       sum_valid;
    logic       sum_ready;
    logic       busy;
    logic [7:0] digit_seg;
    logic [1:0] digit_con;

    logic [4:0] sum_in2;
    logic       sum_valid2;
    logic       sum_ready2;
    logic       busy2;
    logic [7:0] digit_seg2;
    logic [1:0] digit_con2;

    int   checks;
    int   errors;
    exp_t exp_q[$];

    seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sum_in    (sum_in),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .busy      (busy),
        .digit_seg (digit_seg),
        .digit_con (digit_con)
    );

    seg_scan_ctrl #(.REFRESH_DIV(DIV2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sum_in    (sum_in2),
        .sum_valid (sum_valid2),
        .sum_ready (sum_ready2),
        .busy      (busy2),
        .digit_seg (digit_seg2),
        .digit_con (digit_con2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One expectation per upcoming slot boundary
    task automatic push_display(input logic [7:0] tens, input logic [7:0] units);
        exp_t e;
        e.tens  = tens;
        e.units = units;
        exp_q.push_back(e);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < int'(4 * DIV) && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d slot expectations left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Offer one sum, optionally drive a competing value during conversion
    task automatic send(input vec_t v);
        int low_cnt;
        int busy_cnt;
        @(negedge clk);
        chk("ready_idle", 32'(sum_ready), 32'd1);
        sum_in    = v.value;
        sum_valid = 1'b1;
        @(negedge clk);
        if (v.interfere) sum_in = 5'd9;
        else             sum_valid = 1'b0;
        low_cnt  = 0;
        busy_cnt = 0;
        for (int i = 0; i < 20 && !sum_ready; i++) begin
            low_cnt++;
            if (busy) busy_cnt++;
            if (i == 2) sum_valid = 1'b0;
            @(negedge clk);
        end
        sum_valid = 1'b0;
        chk("ready_low_cycles", 32'(low_cnt), 32'd6);
        chk("busy_cycles", 32'(busy_cnt), 32'd6);
        chk("busy_after", 32'(busy), 32'd0);
        push_display(v.tens, v.units);
        wait_drain();
    endtask

    // Monitor: at each slot boundary compare the new slot against the scoreboard
    initial begin : monitor
        logic [1:0] prev;
        int         len;
        exp_t       e;
        prev = 2'b10;
        len  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev = digit_con;
                len  = 0;
            end else begin
                len++;
                if (digit_con != prev) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("slot_length", 32'(len), 32'(DIV));
                        if (digit_con == 2'b01)
                            chk("tens_slot_seg", 32'(digit_seg), 32'(e.tens));
                        else
                            chk("units_slot_seg", 32'({digit_con, digit_seg}), 32'({2'b10, e.units}));
                    end
                    len  = 0;
                    prev = digit_con;
                end
            end
        end
    end

    initial begin : stim
        vec_t       vecs[5];
        logic [1:0] prev2;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b1;
        sum_in     = '0;
        sum_valid  = 1'b0;
        sum_in2    = '0;
        sum_valid2 = 1'b0;

        vecs[0] = '{value: 5'd23, interfere: 1'b0, tens: 8'b11011010, units: 8'b11110010};
        vecs[1] = '{value: 5'd31, interfere: 1'b1, tens: 8'b11110010, units: 8'b01100000};
        vecs[2] = '{value: 5'd0,  interfere: 1'b0, tens: TENS_ZERO,   units: 8'b11111100};
        vecs[3] = '{value: 5'd19, interfere: 1'b0, tens: 8'b01100000, units: 8'b11110110};
        vecs[4] = '{value: 5'd7,  interfere: 1'b0, tens: TENS_ZERO,   units: 8'b11100000};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(sum_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_con", 32'(digit_con), 32'h2);
        chk("rst_seg", 32'(digit_seg), 32'hFC);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_accept_ready", 32'(sum_ready), 32'd1);
        push_display(TENS_ZERO, 8'b11111100);
        wait_drain();

        foreach (vecs[i]) send(vecs[i]);

        // Reset during conversion aborts it
        @(negedge clk);
        sum_in    = 5'd18;
        sum_valid = 1'b1;
        @(negedge clk);
        sum_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_rst_ready", 32'(sum_ready), 32'd0);
        chk("abort_rst_busy", 32'(busy), 32'd0);
        chk("abort_rst_con_seg", 32'({digit_con, digit_seg}), 32'({2'b10, 8'b11111100}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_release_ready", 32'(sum_ready), 32'd1);
        @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_ready", 32'(sum_ready), 32'd1);
        push_display(TENS_ZERO, 8'b11111100);
        wait_drain();

        // REFRESH_DIV=2: align the commit to the middle of a tens slot
        @(negedge clk);
        prev2 = digit_con2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (digit_con2 != prev2 && digit_con2 == 2'b01) break;
            prev2 = digit_con2;
        end
        chk("div2_found_tens", 32'(digit_con2), 32'h1);
        repeat (2) @(negedge clk);
        chk("div2_ready", 32'(sum_ready2), 32'd1);
        sum_in2    = 5'd10;
        sum_valid2 = 1'b1;
        @(negedge clk);
        sum_valid2 = 1'b0;
        repeat (6) @(negedge clk);
        chk("div2_midslot_hold", 32'({digit_con2, digit_seg2}), 32'({2'b01, TENS_ZERO}));
        chk("div2_ready_back", 32'(sum_ready2), 32'd1);
        @(negedge clk);
        chk("div2_units_slot", 32'({digit_con2, digit_seg2}), 32'({2'b10, 8'b11111100}));
        repeat (2) @(negedge clk);
        chk("div2_tens_slot", 32'({digit_con2, digit_seg2}), 32'({2'b01, 8'b01100000}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
